lif_spike_decoder: RTL and testbench
====================================

# lif_spike_decoder

Rate/interval decoder for the LIF neuron's spike output, the consuming end of the neuron's spike interface. Counts rising edges of the spike line over a fixed window of enabled cycles, tracks the most recent inter-spike interval (ISI), and presents one result per window on a valid/ready output port. It sits beside the neuron in the top level. It turns spike trains back into 8-bit rate and ISI words for readout or for driving the next stage's input current.

## Interface
- `WINDOW`, default 256: window length in enabled cycles; legal range 4..65535.
- `CNT_W`, default 8: width of the rate and ISI results; both saturate at 2^CNT_W-1.
- `clk`, input, 1: the single clock; all state is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `ena`, input, 1: advance enable; when low, all state is frozen.
- `spike_in`, input, 1: the neuron spike line, level signal, synchronous to `clk`.
- `out_valid`, output, 1: a result is held on `rate_out`, `isi_out` and `overrun`.
- `out_ready`, input, 1: the consumer accepts the result.
- `rate_out`, output, CNT_W: spike count for the completed window, saturating.
- `isi_out`, output, CNT_W: last ISI in cycles measured by the window end; 0 if fewer than two spikes have ever been seen since reset.
- `overrun`, output, 1: at least one window result was dropped before this one was presented.

## Operation
- Edge detect: `spk_q` holds the previous `spike_in`. A spike event is `spike_in & ~spk_q` in a cycle with `ena=1`. A line held high counts once.
- FSM with two states:
  - ARMED: no spike seen since reset. The first event moves to TRACK and clears `isi_cnt` to 0.
  - TRACK: `isi_cnt` increments by 1 every enabled cycle and saturates at 255. On an event, `isi_last <= isi_cnt + 1` (saturating) and `isi_cnt <= 0`.
- Window counter `win_cnt` runs 0..WINDOW-1 over enabled cycles and wraps to 0. `spk_cnt` increments on each event and saturates.
- End of window (`win_cnt == WINDOW-1` with `ena=1`):
  - The count for that cycle, including any event in that same cycle, is captured into the result.
  - `isi_last` is captured, with that cycle's update applied.
  - `spk_cnt` restarts at 0.
  - The FSM and ISI tracking continue across windows.
- Output register, single entry:
  - Capture when empty, or when the current result is taken in the same cycle (`out_valid & out_ready`). Set `out_valid`.
  - If full and not taken, drop the new result and set `ovr_pend`.
  - Each captured result loads `overrun <= ovr_pend`, then clears `ovr_pend`.
  - Payload is stable while `out_valid=1 & out_ready=0`.
- `out_ready` is ignored while `out_valid=0`. `ena` does not gate the handshake.
- Reset values: `out_valid=0`, `rate_out=0`, `isi_out=0`, `overrun=0`. Internally: FSM=ARMED, all counters 0, `spk_q=0`, `ovr_pend=0`.
- Reset mid-window discards the partial count and any held result.

## Timing
- `spike_in` high in enabled cycle t, low at t-1: counted in cycle t.
- Window closing at cycle t: `out_valid=1` and payload valid from t+1.
- Handshake completes in the cycle where `out_valid & out_ready`. `out_valid` drops at the next edge unless a new window closed in that same cycle.
- Since WINDOW ≥ 4, at most one capture is possible per cycle.
- Throughput is one result per window with `out_ready` tied high.
- ISI definition: events at enabled cycles t0 and t1 give an ISI of t1-t0. Disabled cycles are not counted.

## Structure
- Package `lif_pkg`:
  - `CNT_W` default constant.
  - Saturating-max constant.
  - FSM state enum `{ARMED, TRACK}`.
  - Result struct `{rate, isi, overrun}`.
- Sub-module `sat_counter`: increment, clear and saturate, parameterised by width. Instantiated for `spk_cnt` and `isi_cnt`.
- The window counter is plain wrap-around logic in the top module. The output register is inline.

## Test plan
- Reset, then WINDOW=8, `ena=1`, `spike_in=0`: `out_valid` rises at cycle 8 with rate=0, isi=0, overrun=0; no X on any output after reset.
- Spike pulses at enabled cycles 1, 4 and 7 with WINDOW=8: rate=3, isi=3. Holding `spike_in` high for cycles 1-6 gives rate=1.
- 300 edges in one 1024-cycle window: rate=255. Spikes 400 cycles apart: isi=255.
- `out_ready=0` for three windows, then 1: the first result is held unchanged; the next presented result has overrun=1; the one after has overrun=0.
- Event on cycle WINDOW-1 counts in the closing window. Toggling `ena` low for 5 cycles between two spikes 6 enabled cycles apart gives isi=6.
- `rst_n` asserted mid-window with 2 spikes counted, while `out_valid=1`: outputs clear immediately. After release, the first window reports only post-reset spikes and isi=0 until two new spikes occur.

Source files
------------

// File: rtl/lif_pkg.sv
// lif_pkg: shared widths, FSM states and result type for the LIF spike decoder.
package lif_pkg;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_SAT_MAX = (1 << DEF_CNT_W) - 1;

    typedef enum logic {ARMED, TRACK} state_t;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] rate;
        logic [DEF_CNT_W-1:0] isi;
        logic                 overrun;
    } res_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones; q_inc is the pre-clear next value.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q_inc
);

    logic [W-1:0] q;

    assign q_inc = (inc && q != '1) ? q + 1'b1 : q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else
            q <= clr ? '0 : q_inc;
    end

endmodule

// File: rtl/lif_spike_decoder.sv
// lif_spike_decoder: windowed spike-rate and last-ISI decoder for the LIF neuron,
// presenting one result per window through a single-entry valid/ready register.
module lif_spike_decoder
    import lif_pkg::*;
#(
    parameter int WINDOW = 256,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] rate_out,
    output logic [CNT_W-1:0] isi_out,
    output logic             overrun
);

    localparam int WIN_W = $clog2(WINDOW);

    state_t             state_q, state_d;
    logic               spk_q;
    logic               evt;
    logic               win_end;
    logic               can_load;
    logic               ovr_pend;
    logic [WIN_W-1:0]   win_cnt;
    logic [CNT_W-1:0]   spk_inc;
    logic [CNT_W-1:0]   isi_inc;
    logic [CNT_W-1:0]   isi_last, isi_last_d;

    assign evt      = ena & spike_in & ~spk_q;
    assign win_end  = ena & (win_cnt == WIN_W'(WINDOW - 1));
    assign can_load = ~out_valid | out_ready;

    // spk_inc already includes an event landing on the closing cycle
    sat_counter #(.W(CNT_W)) u_spk_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (win_end),
        .inc   (evt),
        .q_inc (spk_inc)
    );

    sat_counter #(.W(CNT_W)) u_isi_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (evt),
        .inc   (ena & (state_q == TRACK)),
        .q_inc (isi_inc)
    );

    always_comb begin
        state_d    = evt ? TRACK : state_q;
        isi_last_d = (evt && state_q == TRACK) ? isi_inc : isi_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARMED;
            spk_q    <= 1'b0;
            isi_last <= '0;
            win_cnt  <= '0;
        end else if (ena) begin
            state_q  <= state_d;
            spk_q    <= spike_in;
            isi_last <= isi_last_d;
            win_cnt  <= win_end ? '0 : win_cnt + 1'b1;
        end
    end

    // a result closing while the register is full and not being taken is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rate_out  <= '0;
            isi_out   <= '0;
            overrun   <= 1'b0;
            ovr_pend  <= 1'b0;
        end else if (win_end && can_load) begin
            out_valid <= 1'b1;
            rate_out  <= spk_inc;
            isi_out   <= isi_last_d;
            overrun   <= ovr_pend;
            ovr_pend  <= 1'b0;
        end else if (win_end) begin
            ovr_pend  <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lif_spike_decoder.sv
// tb_lif_spike_decoder: directed vectors for the spike decoder at WINDOW=8 and WINDOW=1024.
module tb_lif_spike_decoder;
    import lif_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic       spike_in = 1'b0;
    logic       out_ready = 1'b0;
    logic       a_valid, b_valid;
    logic [7:0] a_rate, a_isi, b_rate, b_isi;
    logic       a_ovr, b_ovr;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    lif_spike_decoder #(.WINDOW(8), .CNT_W(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .spike_in  (spike_in),
        .out_valid (a_valid),
        .out_ready (out_ready),
        .rate_out  (a_rate),
        .isi_out   (a_isi),
        .overrun   (a_ovr)
    );

    lif_spike_decoder #(.WINDOW(1024), .CNT_W(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .spike_in  (spike_in),
        .out_valid (b_valid),
        .out_ready (out_ready),
        .rate_out  (b_rate),
        .isi_out   (b_isi),
        .overrun   (b_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t mk(input int r, input int i, input logic o);
        res_t v;
        v.rate    = 8'(r);
        v.isi     = 8'(i);
        v.overrun = o;
        return v;
    endfunction

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, ".valid"}, 32'(a_valid), 32'd1);
        chk({tag, ".rate"}, 32'(a_rate), 32'(e.rate));
        chk({tag, ".isi"}, 32'(a_isi), 32'(e.isi));
        chk({tag, ".ovr"}, 32'(a_ovr), 32'(e.overrun));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".a"}, {a_valid, a_rate, a_isi, a_ovr}, 32'd0);
        chk({tag, ".b"}, {b_valid, b_rate, b_isi, b_ovr}, 32'd0);
    endtask

    task automatic tick(input logic s);
        spike_in = s;
        @(negedge clk);
    endtask

    task automatic win8(input logic [7:0] p);
        for (int i = 0; i < 8; i++) tick(p[i]);
    endtask

    task automatic do_reset(input string tag);
        ena = 1'b0;
        spike_in = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;
    endtask

    initial begin
        // idle window
        do_reset("rst1");
        repeat (7) tick(1'b0);
        chk("idle.early", 32'(a_valid), 32'd0);
        tick(1'b0);
        chk_res("idle", mk(0, 0, 1'b0));

        // pulses at 1,4,7 then a line held high for 1..6
        do_reset("rst2");
        win8(8'b1001_0010);
        chk_res("pulses", mk(3, 3, 1'b0));
        out_ready = 1'b1;
        win8(8'b0111_1110);
        chk_res("held", mk(1, 2, 1'b0));

        // ena gap between spikes 6 enabled cycles apart
        do_reset("rst3");
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        ena = 1'b0;
        tick(1'b0); tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
        ena = 1'b1;
        tick(1'b0); tick(1'b0); tick(1'b0);
        tick(1'b1);
        chk("gap.early", 32'(a_valid), 32'd0);
        tick(1'b0);
        chk_res("gap", mk(2, 6, 1'b0));

        // back-pressure for three windows
        do_reset("rst4");
        win8(8'b0000_0100);
        chk_res("ovr.w1", mk(1, 0, 1'b0));
        win8(8'b0000_0010);
        chk_res("ovr.hold1", mk(1, 0, 1'b0));
        win8(8'b0000_0000);
        chk_res("ovr.hold2", mk(1, 0, 1'b0));
        out_ready = 1'b1;
        win8(8'b0000_1000);
        chk_res("ovr.w4", mk(1, 18, 1'b1));
        win8(8'b0000_0000);
        chk_res("ovr.w5", mk(0, 18, 1'b0));

        // asynchronous reset mid-window with a held result
        do_reset("rst5");
        win8(8'b0000_1010);
        chk_res("mid.w1", mk(2, 2, 1'b0));
        tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
        chk("mid.valid", 32'(a_valid), 32'd1);
        rst_n = 1'b0;
        #1 chk_zero("mid.rst");
        @(negedge clk);
        rst_n = 1'b1;
        win8(8'b0010_0000);
        chk_res("mid.post1", mk(1, 0, 1'b0));
        out_ready = 1'b1;
        win8(8'b0000_0100);
        chk_res("mid.post2", mk(1, 5, 1'b0));

        // ISI saturation with spikes 400 cycles apart
        do_reset("rst6");
        out_ready = 1'b1;
        tick(1'b1);
        repeat (399) tick(1'b0);
        tick(1'b1);
        repeat (7) tick(1'b0);
        chk_res("isi.sat", mk(1, DEF_SAT_MAX, 1'b0));

        // rate saturation: 300 edges in one 1024-cycle window
        do_reset("rst7");
        repeat (300) begin
            tick(1'b1);
            tick(1'b0);
        end
        repeat (423) tick(1'b0);
        chk("rate.early", 32'(b_valid), 32'd0);
        tick(1'b0);
        chk("rate.valid", 32'(b_valid), 32'd1);
        chk("rate.sat", 32'(b_rate), 32'(DEF_SAT_MAX));
        chk("rate.isi", 32'(b_isi), 32'd2);
        chk("rate.ovr", 32'(b_ovr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
